lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit bus controller: request accept, bus handshake, timeout, response hold
package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_BYTE   = 3'd0,
        MEM_BYTE_U = 3'd1,
        MEM_HALF   = 3'd2,
        MEM_HALF_U = 3'd3,
        MEM_WORD   = 3'd4
    } mem_op_e;
endpackage

module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  mem_op_e         req_mem_op,
    output logic            req_ready,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata_raw,
    output logic            rsp_err,
    output logic            rsp_misaligned,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Access size code; 0 means "no access latched yet" so byte enables read 0 out of reset.
    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [XLEN-1:3+(-1)] addr_hi_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic            mis_q;

    logic            accept;
    logic            rv_done;
    logic            to_done;
    logic            mis_c;
    logic [1:0]      size_c;
    logic [XLEN-1:0] wdata_c;

    // Decode the incoming request: alignment, access size and lane-replicated store data.
    always_comb begin
        mis_c   = 1'b0;
        size_c  = SZ_WORD;
        wdata_c = req_wdata;
        case (req_mem_op)
            MEM_BYTE, MEM_BYTE_U: begin
                size_c  = SZ_BYTE;
                wdata_c = {4{req_wdata[7:0]}};
            end
            MEM_HALF, MEM_HALF_U: begin
                mis_c   = req_addr[0];
                size_c  = SZ_HALF;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                mis_c   = |req_addr[1:0];
                size_c  = SZ_WORD;
                wdata_c = req_wdata;
            end
        endcase
    end

    // Next-state and timeout logic; a response in the last allowed cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        rv_done = 1'b0;
        to_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = mis_c ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    to_done = 1'b1;
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    rv_done = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    to_done = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus request fields latched on accept; response fields cleared on accept and filled on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            addr_hi_q <= '0;
            off_q     <= 2'd0;
            size_q    <= SZ_NONE;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else if (accept) begin
            we_q      <= req_we;
            addr_hi_q <= req_addr[XLEN-1:2];
            off_q     <= req_addr[1:0];
            size_q    <= size_c;
            wdata_q   <= wdata_c;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mis_q     <= mis_c;
        end else if (rv_done) begin
            rdata_q   <= we_q ? '0 : bus_rdata;
            err_q     <= bus_err;
        end else if (to_done) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
        end
    end

    // Byte enables follow the latched size and byte offset.
    always_comb begin
        bus_be = 4'b0000;
        case (size_q)
            SZ_BYTE: bus_be = 4'b0001 << off_q;
            SZ_HALF: bus_be = 4'b0011 << {off_q[1], 1'b0};
            SZ_WORD: bus_be = 4'b1111;
            default: bus_be = 4'b0000;
        endcase
    end

    assign req_ready      = (state_q == S_IDLE);
    assign stall          = ((state_q == S_IDLE) && req_valid) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus_req        = (state_q == S_ISSUE);
    assign rsp_valid      = (state_q == S_DONE);
    assign bus_we         = we_q;
    assign bus_addr       = {addr_hi_q, 2'b00};
    assign bus_wdata      = wdata_q;
    assign rsp_rdata_raw  = rdata_q;
    assign rsp_err        = err_q;
    assign rsp_misaligned = mis_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard testbench for lsu_ctrl
module tb_lsu_ctrl;
    import riscv_pkg::*;

    localparam int T     = 16;
    localparam int LIMIT = T + 20;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    mem_op_e     req_mem_op;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata_raw;
    logic        rsp_err;
    logic        rsp_misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_mem_op(req_mem_op),
        .req_ready(req_ready), .stall(stall),
        .rsp_valid(rsp_valid), .rsp_rdata_raw(rsp_rdata_raw),
        .rsp_err(rsp_err), .rsp_misaligned(rsp_misaligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          lat;
        int          nreq;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int          o_lat;
    int          o_nreq;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_mis;
    logic [3:0]  o_be;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic        o_we;
    logic        o_stall_ok;
    logic        o_stall_done;

    function automatic exp_t model(mem_op_e op, logic we, logic [31:0] a, logic [31:0] w,
                                   int g, int rv, logic [31:0] rd, logic berr);
        exp_t e;
        int   c;
        e.we   = we;
        e.addr = a & 32'hFFFF_FFFC;
        case (op)
            MEM_BYTE, MEM_BYTE_U: begin
                e.mis = 1'b0;
                e.be = 4'b0001 << a[1:0];
                e.wdata = {w[7:0], w[7:0], w[7:0], w[7:0]};
            end
            MEM_HALF, MEM_HALF_U: begin
                e.mis = a[0];
                e.be = a[1] ? 4'b1100 : 4'b0011;
                e.wdata = {w[15:0], w[15:0]};
            end
            default: begin
                e.mis = (a[1:0] != 2'b00);
                e.be = 4'b1111;
                e.wdata = w;
            end
        endcase
        c = g + 2 + rv;
        if (e.mis) begin
            e.lat = 1; e.nreq = 0; e.rdata = 32'h0; e.err = 1'b0;
        end else if (rv >= 0 && g + 1 < T && c <= T) begin
            e.lat = c + 1; e.nreq = g + 1; e.rdata = we ? 32'h0 : rd; e.err = berr;
        end else begin
            e.lat = T + 1; e.nreq = (g + 1 < T) ? g + 1 : T; e.rdata = 32'h0; e.err = 1'b1;
        end
        return e;
    endfunction

    // Drive one access and act as the bus slave; g = ISSUE cycles before gnt, rv = WAIT cycles before rvalid (<0: never).
    task automatic do_access(mem_op_e op, logic we, logic [31:0] a, logic [31:0] w,
                             int g, int rv, logic [31:0] rd, logic berr, logic stray);
        logic got;
        q.push_back(model(op, we, a, w, g, rv, rd, berr));
        o_lat = -1; o_nreq = 0; o_stall_ok = 1'b1; got = 1'b0;
        o_be = 4'hx; o_addr = 32'hx; o_wdata = 32'hx; o_we = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = w; req_mem_op = op;
        #1;
        if (!(stall && req_ready)) o_stall_ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int idx = 1; idx <= LIMIT && !got; idx++) begin
            bus_gnt    = (idx == g + 1);
            bus_rvalid = (rv >= 0 && idx == g + 2 + rv) || (stray && g > 0 && idx == 1);
            bus_rdata  = rd;
            bus_err    = berr;
            #1;
            if (rsp_valid) begin
                got = 1'b1;
                o_lat = idx; o_rdata = rsp_rdata_raw; o_err = rsp_err; o_mis = rsp_misaligned;
                o_stall_done = stall;
                bus_gnt = 1'b0; bus_rvalid = 1'b0;
            end else begin
                if (!stall) o_stall_ok = 1'b0;
                if (bus_req) begin
                    if (o_nreq == 0) begin
                        o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
                    end
                    o_nreq++;
                end
                @(negedge clk);
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", LIMIT);
        end
    endtask

    task automatic apply_reset();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_mem_op = MEM_WORD;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
        checks++; if ({stall, bus_req, rsp_valid, bus_we, rsp_err, rsp_misaligned} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp 000000", {stall, bus_req, rsp_valid, bus_we, rsp_err, rsp_misaligned}); end
        checks++; if ({bus_addr, bus_wdata, rsp_rdata_raw, bus_be} !== 100'b0) begin
            errors++; $display("FAIL reset_data: addr %h wdata %h rdata %h be %b exp 0", bus_addr, bus_wdata, rsp_rdata_raw, bus_be); end
    endtask

    task automatic test_load_word();
        exp_t e;
        do_access(MEM_WORD, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        e = q.pop_front();
        checks++; if (o_lat !== 3 || o_lat !== e.lat) begin errors++; $display("FAIL lw_latency: got %0d exp %0d", o_lat, e.lat); end
        checks++; if (o_be !== 4'b1111 || o_addr !== 32'h100) begin errors++; $display("FAIL lw_bus: be %b addr %h exp 1111 00000100", o_be, o_addr); end
        checks++; if (o_rdata !== e.rdata || o_err !== 1'b0) begin errors++; $display("FAIL lw_rsp: rdata %h err %b exp %h 0", o_rdata, o_err, e.rdata); end
        checks++; if (o_stall_ok !== 1'b1 || o_stall_done !== 1'b0) begin errors++; $display("FAIL lw_stall: busy %b done %b exp 1 0", o_stall_ok, o_stall_done); end
    endtask

    task automatic test_store_byte();
        exp_t e;
        do_access(MEM_BYTE, 1'b1, 32'h203, 32'h000000A5, 1, 2, 32'h12345678, 1'b0, 1'b0);
        e = q.pop_front();
        checks++; if (o_addr !== 32'h200 || o_be !== 4'b1000 || o_be !== e.be) begin errors++; $display("FAIL sb_bus: addr %h be %b exp 00000200 1000", o_addr, o_be); end
        checks++; if (o_wdata !== 32'hA5A5A5A5 || o_we !== 1'b1) begin errors++; $display("FAIL sb_wdata: wdata %h we %b exp a5a5a5a5 1", o_wdata, o_we); end
        checks++; if (o_rdata !== 32'h0 || o_lat !== e.lat || o_nreq !== e.nreq) begin
            errors++; $display("FAIL sb_rsp: rdata %h lat %0d nreq %0d exp 0 %0d %0d", o_rdata, o_lat, o_nreq, e.lat, e.nreq); end
        do_access(MEM_HALF, 1'b1, 32'h412, 32'hCAFEBEEF, 0, 1, 32'h0, 1'b0, 1'b0);
        e = q.pop_front();
        checks++; if (o_be !== e.be || o_wdata !== e.wdata) begin errors++; $display("FAIL sh_bus: be %b wdata %h exp %b %h", o_be, o_wdata, e.be, e.wdata); end
    endtask

    task automatic test_misaligned();
        exp_t e;
        do_access(MEM_HALF, 1'b0, 32'h101, 32'h0, 0, 0, 32'hFFFFFFFF, 1'b0, 1'b0);
        e = q.pop_front();
        checks++; if (o_lat !== 1 || o_nreq !== 0 || o_mis !== 1'b1) begin
            errors++; $display("FAIL lh_mis: lat %0d nreq %0d mis %b exp 1 0 1", o_lat, o_nreq, o_mis); end
        checks++; if (o_stall_ok !== 1'b1 || o_stall_done !== 1'b0 || o_err !== e.err) begin
            errors++; $display("FAIL lh_mis_stall: busy %b done %b err %b exp 1 0 0", o_stall_ok, o_stall_done, o_err); end
        do_access(MEM_WORD, 1'b1, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        e = q.pop_front();
        checks++; if (o_mis !== e.mis || o_nreq !== 0) begin errors++; $display("FAIL sw_mis: mis %b nreq %0d exp 1 0", o_mis, o_nreq); end
        do_access(MEM_BYTE_U, 1'b0, 32'h3, 32'h0, 0, 0, 32'h11223344, 1'b0, 1'b0);
        e = q.pop_front();
        checks++; if (o_mis !== 1'b0 || o_rdata !== e.rdata || o_be !== e.be) begin
            errors++; $display("FAIL lbu_aligned: mis %b rdata %h be %b exp 0 %h %b", o_mis, o_rdata, o_be, e.rdata, e.be); end
    endtask

    task automatic test_timeout();
        exp_t e;
        do_access(MEM_WORD, 1'b0, 32'h300, 32'h0, 3, -1, 32'h55555555, 1'b0, 1'b1);
        e = q.pop_front();
        checks++; if (o_lat !== T + 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
            errors++; $display("FAIL timeout: lat %0d err %b rdata %h exp %0d 1 0", o_lat, o_err, o_rdata, T + 1); end
        do_access(MEM_WORD, 1'b0, 32'h304, 32'h0, 3, T - 5, 32'h87654321, 1'b0, 1'b0);
        e = q.pop_front();
        checks++; if (o_lat !== e.lat || o_err !== 1'b0 || o_rdata !== 32'h87654321) begin
            errors++; $display("FAIL rvalid_wins: lat %0d err %b rdata %h exp %0d 0 87654321", o_lat, o_err, o_rdata, e.lat); end
        do_access(MEM_HALF_U, 1'b0, 32'h306, 32'h0, 0, 0, 32'hABCD0000, 1'b1, 1'b0);
        e = q.pop_front();
        checks++; if (o_err !== e.err || o_rdata !== e.rdata) begin errors++; $display("FAIL bus_err: err %b rdata %h exp 1 %h", o_err, o_rdata, e.rdata); end
    endtask

    task automatic test_done_hold();
        logic [31:0] held;
        do_access(MEM_WORD, 1'b0, 32'h500, 32'h0, 0, 0, 32'h0BADF00D, 1'b0, 1'b0);
        void'(q.pop_front());
        held = 32'h0BADF00D;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h503; req_mem_op = MEM_WORD;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_misaligned !== 1'b0) begin
            errors++; $display("FAIL done_ignore: ready %b valid %b mis %b exp 1 0 0", req_ready, rsp_valid, rsp_misaligned); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rsp_rdata_raw !== held || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rsp_hold: rdata %h err %b exp %h 0", rsp_rdata_raw, rsp_err, held); end
    endtask

    task automatic test_reset_in_wait();
        logic bad;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h700; req_mem_op = MEM_WORD;
        @(negedge clk);
        req_valid = 1'b0; bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: req %b ready %b valid %b exp 0 1 0", bus_req, req_ready, rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hFEEDFACE;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            #1;
            if (rsp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reset_wait_rvalid: stray activity %b exp 0", bad); end
    endtask

    task automatic test_back_to_back();
        exp_t    e;
        mem_op_e op;
        logic    we;
        logic [31:0] a, w, rd;
        int      g, rv, bad;
        bad = 0;
        for (int n = 0; n < 24; n++) begin
            op = mem_op_e'($urandom_range(0, 4));
            we = 1'($urandom_range(0, 1));
            a  = {20'h0, 12'($urandom_range(0, 4095))};
            w  = $urandom; rd = $urandom;
            g  = $urandom_range(0, 4);
            rv = (n % 6 == 5) ? -1 : $urandom_range(0, 4);
            do_access(op, we, a, w, g, rv, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = q.pop_front();
            if (o_lat !== e.lat || o_rdata !== e.rdata || o_err !== e.err || o_mis !== e.mis || o_nreq !== e.nreq ||
                (!e.mis && (o_be !== e.be || o_addr !== e.addr || o_wdata !== e.wdata || o_we !== e.we))) begin
                bad++;
                $display("FAIL b2b_%0d: lat %0d rd %h err %b mis %b be %b addr %h wd %h exp %0d %h %b %b %b %h %h",
                         n, o_lat, o_rdata, o_err, o_mis, o_be, o_addr, o_wdata, e.lat, e.rdata, e.err, e.mis, e.be, e.addr, e.wdata);
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL back_to_back: %0d bad accesses exp 0", bad); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_misaligned();
        test_timeout();
        test_done_hold();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
